// File: rtl/stream_framer.sv
// Transmit-side framer: cuts an unframed word stream into first/last-marked frames
// of a configured length (or shorter on flush) behind a single register slice.
module stream_framer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              flush,
    input  logic              valid_rx,
    output logic              ready_rx,
    input  logic [DATA_W-1:0] payload_rx,
    output logic              valid_tx,
    input  logic              ready_tx,
    output logic              first_tx,
    output logic              last_tx,
    output logic [DATA_W-1:0] payload_tx,
    output logic [CNT_W-1:0]  frame_count,
    output logic              in_frame
);

    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_lat_q, len_lat_d;
    logic              flush_pending_q, flush_pending_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;

    logic              accept_c;
    logic              idle_c;
    logic              is_last_c;
    logic [LEN_W-1:0]  eff_len_c;
    logic [LEN_W-1:0]  cur_len_c;
    logic [LEN_W-1:0]  idx_inc_c;

    // The slice can take a new word whenever it is empty or draining this cycle.
    assign ready_rx = !valid_q || ready_tx;
    assign in_frame = (idx_q != '0);

    always_comb begin
        idx_d           = idx_q;
        len_lat_d       = len_lat_q;
        flush_pending_d = flush_pending_q;
        valid_d         = valid_q;
        first_d         = first_q;
        last_d          = last_q;
        payload_d       = payload_q;
        frame_count_d   = frame_count_q;

        accept_c  = valid_rx && ready_rx;
        idle_c    = (idx_q == '0);
        eff_len_c = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        cur_len_c = idle_c ? eff_len_c : len_lat_q;
        idx_inc_c = idx_q + LEN_W'(1);
        is_last_c = flush || flush_pending_q || (idx_inc_c == cur_len_c);

        if (accept_c) begin
            valid_d         = 1'b1;
            payload_d       = payload_rx;
            first_d         = idle_c;
            last_d          = is_last_c;
            idx_d           = is_last_c ? '0 : idx_inc_c;
            flush_pending_d = 1'b0;
            if (idle_c) begin
                len_lat_d = eff_len_c;
            end
        end else begin
            if (ready_tx) begin
                valid_d = 1'b0;
            end
            // A flush with nothing open is dropped so empty frames never appear.
            if (flush && !idle_c) begin
                flush_pending_d = 1'b1;
            end
        end

        if (valid_q && ready_tx && last_q) begin
            frame_count_d = frame_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q           <= '0;
            len_lat_q       <= '0;
            flush_pending_q <= 1'b0;
            valid_q         <= 1'b0;
            first_q         <= 1'b0;
            last_q          <= 1'b0;
            payload_q       <= '0;
            frame_count_q   <= '0;
        end else begin
            idx_q           <= idx_d;
            len_lat_q       <= len_lat_d;
            flush_pending_q <= flush_pending_d;
            valid_q         <= valid_d;
            first_q         <= first_d;
            last_q          <= last_d;
            payload_q       <= payload_d;
            frame_count_q   <= frame_count_d;
        end
    end

    assign valid_tx    = valid_q;
    assign first_tx    = first_q;
    assign last_tx     = last_q;
    assign payload_tx  = payload_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_stream_framer.sv
// Scoreboard bench for stream_framer: directed words push hand-computed
// expectations; a negedge monitor pops and compares on every tx handshake.
module tb_stream_framer;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_len;
    logic        flush;
    logic        valid_rx;
    logic        ready_rx;
    logic [31:0] payload_rx;
    logic        valid_tx;
    logic        ready_tx;
    logic        first_tx;
    logic        last_tx;
    logic [31:0] payload_tx;
    logic [15:0] frame_count;
    logic        in_frame;

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        l;
    } exp_t;

    exp_t expq[$];
    int   n_cmp;
    int   n_bad;
    int   stall_cycles;

    stream_framer #(.DATA_W(32), .LEN_W(16), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_len     (cfg_len),
        .flush       (flush),
        .valid_rx    (valid_rx),
        .ready_rx    (ready_rx),
        .payload_rx  (payload_rx),
        .valid_tx    (valid_tx),
        .ready_tx    (ready_tx),
        .first_tx    (first_tx),
        .last_tx     (last_tx),
        .payload_tx  (payload_tx),
        .frame_count (frame_count),
        .in_frame    (in_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && valid_tx === 1'b1 && ready_tx === 1'b1) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %0h expected none", payload_tx);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("tx_payload", 64'(payload_tx), 64'(e.d));
                chk("tx_first",   64'(first_tx),   64'(e.f));
                chk("tx_last",    64'(last_tx),    64'(e.l));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic f, input logic l, input logic fl);
        logic acc;
        expq.push_back('{d: d, f: f, l: l});
        valid_rx   = 1'b1;
        payload_rx = d;
        flush      = fl;
        acc        = 1'b0;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = ready_rx;
            @(posedge clk);
            #1;
            if (!acc) stall_cycles++;
        end
        if (!acc) chk("accept_timeout", 64'(0), 64'(1));
        valid_rx = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 64 && expq.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        chk("drain_left", 64'(expq.size()), 64'(0));
    endtask

    task automatic idle_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Asserted asynchronously from wherever the caller stands; the held word is discarded.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid_tx",    64'(valid_tx),    64'(0));
        chk("rst_first_tx",    64'(first_tx),    64'(0));
        chk("rst_last_tx",     64'(last_tx),     64'(0));
        chk("rst_payload_tx",  64'(payload_tx),  64'(0));
        chk("rst_frame_count", 64'(frame_count), 64'(0));
        chk("rst_in_frame",    64'(in_frame),    64'(0));
        expq.delete();
        valid_rx = 1'b0;
        flush    = 1'b0;
        ready_tx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        stall_cycles = 0;
        rst          = 1'b0;
        cfg_len      = 16'd4;
        flush        = 1'b0;
        valid_rx     = 1'b0;
        payload_rx   = '0;
        ready_tx     = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Length 4, eight words at full rate.
        cfg_len = 16'd4;
        for (int i = 0; i < 8; i++) begin
            send(32'(i), (i % 4) == 0, (i % 4) == 3, 1'b0);
        end
        chk("t1_no_stall", 64'(stall_cycles), 64'(0));
        wait_drain();
        chk("t1_frame_count", 64'(frame_count), 64'(2));
        do_reset();

        // Downstream stall of three cycles while word 1 is held.
        cfg_len = 16'd4;
        send(32'h10, 1'b1, 1'b0, 1'b0);
        send(32'h11, 1'b0, 1'b0, 1'b0);
        ready_tx = 1'b0;
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_ready_rx", 64'(ready_rx),   64'(0));
                    chk("t2_valid",    64'(valid_tx),   64'(1));
                    chk("t2_hold",     64'(payload_tx), 64'h11);
                end
                @(posedge clk);
                #1;
                ready_tx = 1'b1;
            end
            begin
                send(32'h12, 1'b0, 1'b0, 1'b0);
                send(32'h13, 1'b0, 1'b1, 1'b0);
            end
        join
        wait_drain();
        chk("t2_frame_count", 64'(frame_count), 64'(1));
        do_reset();

        // Zero length behaves as single-word frames.
        cfg_len = 16'd0;
        for (int i = 0; i < 3; i++) begin
            send(32'h20 + 32'(i), 1'b1, 1'b1, 1'b0);
        end
        wait_drain();
        chk("t3_frame_count", 64'(frame_count), 64'(3));
        do_reset();

        // Flush on an idle cycle mid-frame, flush while idle, flush with a word.
        cfg_len = 16'd8;
        send(32'hA0, 1'b1, 1'b0, 1'b0);
        send(32'hA1, 1'b0, 1'b0, 1'b0);
        chk("t4_in_frame_open", 64'(in_frame), 64'(1));
        idle_flush();
        send(32'hA2, 1'b0, 1'b1, 1'b0);
        chk("t4_in_frame_closed", 64'(in_frame), 64'(0));
        idle_flush();
        chk("t4_idle_flush_ignored", 64'(in_frame), 64'(0));
        send(32'hA3, 1'b1, 1'b0, 1'b0);
        send(32'hA4, 1'b0, 1'b0, 1'b0);
        send(32'hA5, 1'b0, 1'b1, 1'b1);
        wait_drain();
        chk("t4_frame_count", 64'(frame_count), 64'(2));
        do_reset();

        // Length change mid-frame only applies to the next frame.
        cfg_len = 16'd4;
        send(32'hB0, 1'b1, 1'b0, 1'b0);
        cfg_len = 16'd2;
        send(32'hB1, 1'b0, 1'b0, 1'b0);
        send(32'hB2, 1'b0, 1'b0, 1'b0);
        send(32'hB3, 1'b0, 1'b1, 1'b0);
        send(32'hB4, 1'b1, 1'b0, 1'b0);
        send(32'hB5, 1'b0, 1'b1, 1'b0);
        wait_drain();
        chk("t5_frame_count", 64'(frame_count), 64'(2));
        do_reset();

        // Reset in the middle of a frame restarts framing cleanly.
        cfg_len = 16'd4;
        send(32'hC0, 1'b1, 1'b0, 1'b0);
        send(32'hC1, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("t6_count_after_rst", 64'(frame_count), 64'(0));
        send(32'hC2, 1'b1, 1'b0, 1'b0);
        send(32'hC3, 1'b0, 1'b0, 1'b0);
        send(32'hC4, 1'b0, 1'b0, 1'b0);
        send(32'hC5, 1'b0, 1'b1, 1'b0);
        wait_drain();
        chk("t6_frame_count", 64'(frame_count), 64'(1));

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
